// File: rtl/systolic_controller.sv
// systolic_controller: loads A/B operand buffers and streams skewed rows/columns into an N x N systolic array.
module systolic_controller #(
    parameter int N    = 2,
    parameter int KMAX = 8,
    parameter int DW   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(KMAX+1)-1:0] k_len,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [$clog2(KMAX)-1:0]   wr_row,
    input  logic [$clog2(KMAX)-1:0]   wr_col,
    input  logic [DW-1:0]             wr_data,
    output logic [N*DW-1:0]           a_feed,
    output logic [N*DW-1:0]           b_feed,
    output logic                      arr_clr,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int KW = $clog2(KMAX+1);
    localparam int AW = $clog2(KMAX);
    localparam int TW = $clog2(KMAX+2*N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KW-1:0]   k_q, k_d;
    logic            err_q, err_d;
    logic [N*DW-1:0] a_q, a_d, b_q, b_d;
    logic [DW-1:0]   a_buf_q [N][KMAX];
    logic [DW-1:0]   b_buf_q [KMAX][N];
    logic            wr_ok;

    assign wr_ok   = wr_en && state_q == IDLE;
    assign a_feed  = a_q;
    assign b_feed  = b_q;
    assign arr_clr = state_q == CLEAR;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign err     = err_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (k_len != '0 && k_len <= KW'(KMAX)) begin
                    k_d     = k_len;
                    state_d = CLEAR;
                end else begin
                    err_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: if (t_q + TW'(1) == TW'(k_q) + TW'(N-1)) begin
                state_d = DRAIN;
                t_d     = '0;
            end else begin
                t_d = t_q + TW'(1);
            end
            DRAIN: if (t_q == TW'(2*N-2)) begin
                state_d = DONE;
                t_d     = '0;
            end else begin
                t_d = t_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Feeds are computed from the next step so the registered outputs line up with step t.
    for (genvar i = 0; i < N; i++) begin : g_feed
        logic [TW-1:0] ti;
        assign ti = t_d - TW'(i);
        assign a_d[i*DW +: DW] = (state_d == FEED && t_d >= TW'(i) && ti < TW'(k_d)) ? a_buf_q[i][AW'(ti)] : '0;
        assign b_d[i*DW +: DW] = (state_d == FEED && t_d >= TW'(i) && ti < TW'(k_d)) ? b_buf_q[AW'(ti)][i] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_buf_q <= '{default: '0};
            b_buf_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < KMAX; c++) begin
                    if (wr_ok && !wr_sel && wr_row == AW'(r) && wr_col == AW'(c))
                        a_buf_q[r][c] <= wr_data;
                    if (wr_ok && wr_sel && wr_row == AW'(c) && wr_col == AW'(r))
                        b_buf_q[c][r] <= wr_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_controller.sv
// tb_systolic_controller: directed checks of the controller driving a behavioural 2x2 systolic array.
module tb_systolic_controller;
    logic        clk = 1'b0;
    logic        reset, start, wr_en, wr_sel;
    logic [3:0]  k_len;
    logic [2:0]  wr_row, wr_col;
    logic [15:0] wr_data;
    logic [31:0] a_feed, b_feed;
    logic        arr_clr, busy, done, err;
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          seen;
    int          acc [2][2];
    int          ap  [2][2];
    int          bp  [2][2];

    systolic_controller #(.N(2), .KMAX(8), .DW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .a_feed(a_feed), .b_feed(b_feed), .arr_clr(arr_clr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Output-stationary array: A flows right, B flows down, each PE accumulates a*b.
    initial acc = '{default: 0};
    initial ap  = '{default: 0};
    initial bp  = '{default: 0};
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                automatic int ai = (j == 0) ? int'(a_feed[i*16 +: 16]) : ap[i][j-1];
                automatic int bi = (i == 0) ? int'(b_feed[j*16 +: 16]) : bp[i-1][j];
                acc[i][j] <= arr_clr ? 0 : acc[i][j] + ai * bi;
                ap[i][j]  <= ai;
                bp[i][j]  <= bi;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int v);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = r[2:0];
        wr_col  = c[2:0];
        wr_data = v[15:0];
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_std();
        wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
        wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
    endtask

    task automatic res(input string tag, input int r00, input int r01, input int r10, input int r11);
        chk({tag, "_c00"}, 64'(acc[0][0]), 64'(r00));
        chk({tag, "_c01"}, 64'(acc[0][1]), 64'(r01));
        chk({tag, "_c10"}, 64'(acc[1][0]), 64'(r10));
        chk({tag, "_c11"}, 64'(acc[1][1]), 64'(r11));
    endtask

    // Waits for done from the cycle after CLEAR, then tries a start in the DONE cycle.
    task automatic finish_run(input string tag, input int from, input int exp_cyc);
        cyc = from;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        start = 1'b1;
        k_len = 4'd2;
        tick();
        start = 1'b0;
        chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic run_k(input string tag, input int k, input int exp_cyc);
        start = 1'b1;
        k_len = k[3:0];
        tick();
        start = 1'b0;
        finish_run(tag, 1, exp_cyc);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
        k_len = '0; wr_row = '0; wr_col = '0; wr_data = '0;
        #12;
        chk("rst_feeds", {a_feed, b_feed}, 64'd0);
        chk("rst_ctrl", {60'd0, arr_clr, busy, done, err}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        load_std();
        wr(0, 1, 1, 0);
        wr(0, 2, 0, 55);
        wr(1, 0, 2, 55);
        // Run 1: the A[1][1] write shares the start cycle and must be seen.
        start = 1'b1; k_len = 4'd2;
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd1; wr_col = 3'd1; wr_data = 16'd4;
        tick();
        start = 1'b0; wr_en = 1'b0;
        chk("c1_clear", {61'd0, arr_clr, busy, err}, 64'b110);
        chk("c1_feeds", {a_feed, b_feed}, 64'd0);
        tick();
        chk("t0_a", 64'(a_feed), 64'h0000_0001);
        chk("t0_b", 64'(b_feed), 64'h0000_0005);
        chk("t0_clr", 64'(arr_clr), 64'd0);
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_data = 16'd99;
        start = 1'b1; k_len = 4'd2;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("t1_a", 64'(a_feed), 64'h0003_0002);
        chk("t1_b", 64'(b_feed), 64'h0006_0007);
        chk("busy_start_err", 64'(err), 64'd0);
        tick();
        chk("t2_a", 64'(a_feed), 64'h0004_0000);
        chk("t2_b", 64'(b_feed), 64'h0008_0000);
        tick();
        chk("drain_feeds", {a_feed, b_feed}, 64'd0);
        chk("drain_busy", {62'd0, busy, done}, 64'b10);
        finish_run("run1", 5, 8);
        res("run1", 19, 22, 43, 50);
        run_k("rerun", 2, 8);
        res("rerun", 19, 22, 43, 50);
        // Rejected starts.
        start = 1'b1; k_len = 4'd0;
        tick();
        start = 1'b0;
        chk("k0_err", {62'd0, err, busy}, 64'b10);
        chk("k0_feeds", {a_feed, b_feed}, 64'd0);
        tick();
        chk("k0_err_pulse", 64'(err), 64'd0);
        start = 1'b1; k_len = 4'd9;
        tick();
        start = 1'b0;
        chk("k9_err", {62'd0, err, busy}, 64'b10);
        tick();
        chk("k9_err_pulse", {62'd0, err, busy}, 64'd0);
        // Abort mid-FEED with asynchronous reset.
        start = 1'b1; k_len = 4'd2;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_feeds", {a_feed, b_feed}, 64'd0);
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_k("zeroed", 2, 8);
        res("zeroed", 0, 0, 0, 0);
        load_std();
        run_k("reload", 2, 8);
        res("reload", 19, 22, 43, 50);
        // Full-depth run.
        for (int c = 0; c < 8; c++) begin
            wr(0, 0, c, 1); wr(0, 1, c, 1);
            wr(1, c, 0, 2); wr(1, c, 1, 2);
        end
        run_k("kmax", 8, 14);
        res("kmax", 16, 16, 16, 16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_controller.md
SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

Interface
REQ-001 SHALL have parameter N, default 2, meaning array dimension (N x N PEs).
REQ-002 SHALL have parameter KMAX, default 8, meaning maximum inner dimension K.
REQ-003 SHALL have parameter DW, default 16, meaning operand width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to run one matrix product; sampled only in IDLE.
REQ-007 k_len  input  $clog2(KMAX+1)  inner dimension K, sampled with accepted start.
REQ-008 wr_en  input  1  operand buffer write strobe.
REQ-009 wr_sel  input  1  0 = A buffer (N x KMAX), 1 = B buffer (KMAX x N).
REQ-010 wr_row, wr_col  input  $clog2(KMAX) each  element row/column address.
REQ-011 wr_data  input  DW  element value.
REQ-012 a_feed  output  N*DW  row operands to array; row i at bits [DW*i+DW-1:DW*i].
REQ-013 b_feed  output  N*DW  column operands to array; column j at same packing.
REQ-014 arr_clr  output  1  active-high clear for array accumulators.
REQ-015 busy  output  1  high in any state but IDLE.
REQ-016 done  output  1  one-cycle pulse at completion.
REQ-017 err  output  1  one-cycle pulse on rejected start.

Function
REQ-018 SHALL implement FSM IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-019 IDLE: start=1 with 1<=k_len<=KMAX SHALL latch K and go to CLEAR next edge.
REQ-020 IDLE: start=1 with k_len=0 or k_len>KMAX SHALL stay IDLE and pulse err next cycle.
REQ-021 start while busy SHALL be ignored (no err, no state effect).
REQ-022 CLEAR SHALL last exactly 1 cycle with arr_clr=1; arr_clr SHALL be 0 in all other states.
REQ-023 FEED SHALL last K+N-1 cycles, step counter t = 0..K+N-2.
REQ-024 In FEED step t, row i SHALL carry A[i][t-i] if 0<=t-i<K, else 0.
REQ-025 In FEED step t, column j SHALL carry B[t-j][j] if 0<=t-j<K, else 0.
REQ-026 a_feed/b_feed SHALL be registered outputs and all-zero outside FEED.
REQ-027 DRAIN SHALL last 2N-1 cycles with zero feeds.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE; start in that cycle ignored.
REQ-029 Start accepted at cycle 0 SHALL yield done=1 in cycle K+3N exactly.
REQ-030 Writes SHALL be accepted only in IDLE; writes while busy SHALL be dropped.
REQ-031 Writes with out-of-range address (A: row>=N or col>=KMAX; B: row>=KMAX or col>=N) SHALL be dropped.
REQ-032 Write and accepted start in the same IDLE cycle: write SHALL complete first and be visible to the run.
REQ-033 Buffers SHALL retain contents across runs; only elements with index < K read per run.
REQ-034 Counters SHALL not wrap: t reaching its terminal value forces the state transition.

Reset
REQ-035 reset=0 SHALL asynchronously force IDLE, clear t and K, zero both buffers.
REQ-036 During and after reset: a_feed=0, b_feed=0, arr_clr=0, busy=0, done=0, err=0.
REQ-037 Reset asserted mid-FEED/DRAIN SHALL abort the run; no done pulse SHALL follow.

Verification
REQ-038 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], K=2, start at cycle 0 -> done at cycle 8; attached 2x2 array results [[19,22],[43,50]].
REQ-039 Same setup, check FEED steps t=0..2: a_feed rows (1,0),(2,3),(0,4); b_feed cols (5,0),(7,6),(0,8).
REQ-040 start with k_len=0, then with k_len=KMAX+1 -> err pulse each time, busy stays 0, feeds stay 0.
REQ-041 wr_en during FEED with value 99 at A[0][0], then rerun K=2 -> results unchanged [[19,22],[43,50]].
REQ-042 reset low at cycle 4 of a run -> busy=0 and feeds=0 immediately, no done; new run after re-load yields correct results.
REQ-043 K=KMAX=8, A all ones, B all twos -> done at cycle 14 and every result = 16.
